// File: rtl/tag_frame_sequencer_if.sv
// Payload ROM and ADC bus shared by the tag frame sequencer and its peripherals.
//   rom_addr : payload ROM address (sequencer -> ROM)
//   rom_data : payload ROM byte, valid one cycle after rom_addr (ROM -> sequencer)
//   adc_soc  : ADC start-of-conversion pulse (sequencer -> ADC)
//   adc_eoc  : ADC end-of-conversion strobe (ADC -> sequencer)
//   adc_data : ADC result (ADC -> sequencer)
interface tag_frame_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              adc_soc;
    logic              adc_eoc;
    logic [7:0]        adc_data;

    modport master (
        output rom_addr,
        output adc_soc,
        input  rom_data,
        input  adc_eoc,
        input  adc_data
    );

    modport slave (
        input  rom_addr,
        input  adc_soc,
        output rom_data,
        output adc_eoc,
        output adc_data
    );
endinterface

// File: rtl/tag_frame_sequencer.sv
// Tag frame sequencer: on a packet envelope (trig) it walks INFO -> GAP -> DATA -> [FCS] ->
// WAIT_END, timing everything on a microsecond tick, serialising payload ROM bytes LSB-first
// onto mod_bit and optionally appending an inverted reflected CRC-32.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   trig              : packet-present envelope; dropping it aborts the frame
//   force_fs          : forces the carrier on (FORCE state), overrides trig
//   mode              : 2'b10 = 11b, 2'b01 = 11n, anything else keeps the block idle
//   bus               : ROM address/data and ADC soc/eoc/data (master side)
//   rss               : last ADC result captured in INFO/GAP (0xFF after INFO entry)
//   fs_en             : carrier enable (all states except IDLE)
//   mod_bit           : modulation bit, meaningful while mod_active
//   mod_active        : high in DATA and FCS
//   frame_done        : one-cycle pulse on WAIT_END entry
//   busy              : state is neither IDLE nor FORCE
module tag_frame_sequencer #(
    parameter int CLK_PER_US  = 50,
    parameter int ADDR_W      = 6,
    parameter int B_INFO_US   = 3,
    parameter int B_GAP_US    = 141,
    parameter int B_LEN_BYTES = 40,
    parameter bit B_CRC_EN    = 1'b1,
    parameter int N_INFO_US   = 2,
    parameter int N_GAP_US    = 64,
    parameter int N_LEN_BYTES = 16,
    parameter bit N_CRC_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trig,
    input  logic                  force_fs,
    input  logic [1:0]            mode,
    tag_frame_sequencer_if.master bus,
    output logic [7:0]            rss,
    output logic                  fs_en,
    output logic                  mod_bit,
    output logic                  mod_active,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int DIV_W = (CLK_PER_US > 2) ? $clog2(CLK_PER_US) : 1;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    typedef enum logic [2:0] {
        StIdle, StForce, StInfo, StGap, StData, StFcs, StWaitEnd
    } state_t;

    state_t            state_q, state_d;
    logic              mode_b_q, mode_b_d;  // 1 = 11b latched, 0 = 11n latched
    logic [DIV_W-1:0]  div_q;
    logic [15:0]       tcnt_q;
    logic [7:0]        sh_q;
    logic [31:0]       crc_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              adc_soc_q;

    logic              tick;
    logic              entering;
    logic [15:0]       info_ticks, gap_ticks, data_ticks;
    logic              crc_en;
    logic [31:0]       crc_step;

    assign bus.rom_addr = rom_addr_q;
    assign bus.adc_soc  = adc_soc_q;

    always_comb begin
        tick       = (div_q == DIV_W'(CLK_PER_US - 1));
        info_ticks = mode_b_q ? 16'(B_INFO_US) : 16'(N_INFO_US);
        gap_ticks  = mode_b_q ? 16'(B_GAP_US) : 16'(N_GAP_US);
        data_ticks = mode_b_q ? 16'(B_LEN_BYTES * 8) : 16'(N_LEN_BYTES * 8);
        crc_en     = mode_b_q ? B_CRC_EN : N_CRC_EN;
        // The bit being shifted in is the one currently on mod_bit.
        crc_step   = {1'b0, crc_q[31:1]} ^ ((crc_q[0] ^ mod_bit) ? CRC_POLY : 32'h0);

        state_d  = state_q;
        mode_b_d = mode_b_q;
        if (force_fs) begin
            state_d = StForce;
        end else if (!trig) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mode == 2'b10 || mode == 2'b01) begin
                        state_d  = StInfo;
                        mode_b_d = (mode == 2'b10);
                    end
                end
                StForce: state_d = StIdle;
                StInfo: begin
                    if (tick && tcnt_q == info_ticks - 16'd1) state_d = StGap;
                end
                StGap: begin
                    if (tick && tcnt_q == gap_ticks - 16'd1) state_d = StData;
                end
                StData: begin
                    if (tick && tcnt_q == data_ticks - 16'd1) begin
                        state_d = crc_en ? StFcs : StWaitEnd;
                    end
                end
                StFcs: begin
                    if (tick && tcnt_q == 16'd31) state_d = StWaitEnd;
                end
                StWaitEnd: state_d = StWaitEnd;
                default:   state_d = StIdle;
            endcase
        end
        entering = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mode_b_q   <= 1'b0;
            div_q      <= '0;
            tcnt_q     <= '0;
            sh_q       <= '0;
            crc_q      <= '0;
            rom_addr_q <= '0;
            adc_soc_q  <= 1'b0;
            rss        <= 8'hFF;
            fs_en      <= 1'b0;
            mod_bit    <= 1'b0;
            mod_active <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_b_q <= mode_b_d;
            div_q    <= (entering || tick) ? '0 : div_q + DIV_W'(1);
            if (entering)  tcnt_q <= '0;
            else if (tick) tcnt_q <= tcnt_q + 16'd1;

            // Outputs are registered from the next state so they line up with state_q.
            adc_soc_q  <= entering && (state_d == StInfo);
            frame_done <= entering && (state_d == StWaitEnd);
            fs_en      <= (state_d != StIdle);
            busy       <= (state_d != StIdle) && (state_d != StForce);
            mod_active <= (state_d == StData) || (state_d == StFcs);

            if (entering && state_d == StInfo) begin
                rss <= 8'hFF;
            end else if (bus.adc_eoc && (state_q == StInfo || state_q == StGap)) begin
                rss <= bus.adc_data;
            end

            if (state_q == StGap && state_d == StData) begin
                // rom_addr has been 0 throughout GAP, so rom_data already holds byte 0.
                sh_q       <= bus.rom_data;
                mod_bit    <= bus.rom_data[0];
                rom_addr_q <= ADDR_W'(1);
                crc_q      <= 32'hFFFF_FFFF;
            end else if (state_q == StData && state_d == StData) begin
                if (tick) begin
                    crc_q <= crc_step;
                    if (tcnt_q[2:0] == 3'd7) begin
                        sh_q       <= bus.rom_data;
                        mod_bit    <= bus.rom_data[0];
                        rom_addr_q <= rom_addr_q + ADDR_W'(1);
                    end else begin
                        sh_q    <= {1'b0, sh_q[7:1]};
                        mod_bit <= sh_q[1];
                    end
                end
            end else if (state_q == StData && state_d == StFcs) begin
                crc_q   <= crc_step;
                mod_bit <= ~crc_step[0];
            end else if (state_q == StFcs && state_d == StFcs) begin
                if (tick) begin
                    crc_q   <= {1'b0, crc_q[31:1]};
                    mod_bit <= ~crc_q[1];
                end
            end else begin
                mod_bit <= 1'b0;
                if (state_d != StWaitEnd) rom_addr_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_tag_frame_sequencer.sv
module tb_tag_frame_sequencer;
    localparam int CPU = 4;

    logic       clk;
    logic       reset;
    logic       trig;
    logic       force_fs;
    logic [1:0] mode;
    logic [7:0] rss;
    logic       fs_en, mod_bit, mod_active, frame_done, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [0:63];

    tag_frame_sequencer_if #(.ADDR_W(6)) bus ();

    tag_frame_sequencer #(
        .CLK_PER_US (CPU),
        .ADDR_W     (6),
        .B_INFO_US  (2),
        .B_GAP_US   (4),
        .B_LEN_BYTES(9),
        .B_CRC_EN   (1'b1),
        .N_INFO_US  (2),
        .N_GAP_US   (3),
        .N_LEN_BYTES(2),
        .N_CRC_EN   (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trig      (trig),
        .force_fs  (force_fs),
        .mode      (mode),
        .bus       (bus),
        .rss       (rss),
        .fs_en     (fs_en),
        .mod_bit   (mod_bit),
        .mod_active(mod_active),
        .frame_done(frame_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    typedef struct {
        logic       trig;
        logic       force_fs;
        logic [1:0] mode;
        logic       exp_fs_en;
        logic       exp_busy;
        logic       exp_soc;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic payload_bit(input int k);
        logic [7:0] b;
        b = rom[k / 8];
        return b[k % 8];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " rom_addr"}, 32'(bus.rom_addr), 0);
        check({tag, " adc_soc"}, 32'(bus.adc_soc), 0);
        check({tag, " fs_en"}, 32'(fs_en), 0);
        check({tag, " mod_bit"}, 32'(mod_bit), 0);
        check({tag, " mod_active"}, 32'(mod_active), 0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " rss"}, 32'(rss), 32'hFF);
    endtask

    // Steps until mod_active is seen; n is the number of steps taken.
    task automatic wait_for_data(input string tag, output int n);
        n = 0;
        while (mod_active !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        if (mod_active !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s data timeout: got mod_active=%0b want 1", tag, mod_active);
        end
    endtask

    // Starting on the DATA entry cycle, checks every bit is held for CPU cycles, then
    // checks the WAIT_END entry pulse.
    task automatic run_bits(input string tag, input int nbits, input bit crc_en,
                            input logic [31:0] fcs);
        int total;
        logic exp, bad_val;
        bit ok;
        total = nbits + (crc_en ? 32 : 0);
        for (int k = 0; k < total; k++) begin
            exp = (k < nbits) ? payload_bit(k) : fcs[k - nbits];
            ok = 1'b1;
            bad_val = exp;
            for (int c = 0; c < CPU; c++) begin
                if (ok && (mod_bit !== exp || mod_active !== 1'b1)) begin
                    ok = 1'b0;
                    bad_val = mod_bit;
                end
                step();
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s bit %0d: got %0b want %0b (held %0d cycles)",
                         tag, k, bad_val, exp, CPU);
            end
        end
        check({tag, " frame_done at end"}, 32'(frame_done), 1);
        check({tag, " mod_active at end"}, 32'(mod_active), 0);
        check({tag, " busy in WAIT_END"}, 32'(busy), 1);
    endtask

    task automatic count_done(input string tag, input int cycles, input int exp);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (frame_done === 1'b1) cnt++;
        end
        check({tag, " frame_done pulses"}, 32'(cnt), 32'(exp));
    endtask

    initial begin
        int n;
        string s;

        foreach (rom[i]) rom[i] = 8'h00;
        for (int i = 0; i < 9; i++) rom[i] = 8'h31 + 8'(i);  // "123456789"

        //           trig force mode   fs busy soc
        vecs[0]  = '{1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        trig = 1'b1;
        force_fs = 1'b1;
        mode = 2'b10;
        bus.adc_eoc = 1'b0;
        bus.adc_data = 8'h00;
        repeat (3) step();
        check_reset_outputs("reset");
        force_fs = 1'b0;
        trig = 1'b0;
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            trig = vecs[i].trig;
            force_fs = vecs[i].force_fs;
            mode = vecs[i].mode;
            step();
            s = $sformatf("vec%0d", i);
            check({s, " fs_en"}, 32'(fs_en), 32'(vecs[i].exp_fs_en));
            check({s, " busy"}, 32'(busy), 32'(vecs[i].exp_busy));
            check({s, " adc_soc"}, 32'(bus.adc_soc), 32'(vecs[i].exp_soc));
            check({s, " mod_active"}, 32'(mod_active), 0);
        end

        // 11b frame with FCS and ADC capture during GAP.
        trig = 1'b0;
        step();
        trig = 1'b1;
        mode = 2'b10;
        step();
        check("11b INFO entry soc", 32'(bus.adc_soc), 1);
        check("11b INFO entry rss", 32'(rss), 32'hFF);
        repeat (10) step();
        bus.adc_eoc = 1'b1;
        bus.adc_data = 8'h5A;
        step();
        bus.adc_eoc = 1'b0;
        bus.adc_data = 8'h00;
        wait_for_data("11b", n);
        check("11b INFO->DATA cycles", 32'(11 + n), 24);
        run_bits("11b", 72, 1'b1, 32'hCBF43926);
        check("11b rss in WAIT_END", 32'(rss), 32'h5A);
        count_done("11b hold", 10, 0);
        check("11b still WAIT_END", 32'(busy), 1);

        // 11n frame: mode change after latch must be ignored.
        trig = 1'b0;
        step();
        check("idle busy", 32'(busy), 0);
        check("rss held in IDLE", 32'(rss), 32'h5A);
        trig = 1'b1;
        mode = 2'b01;
        step();
        check("11n INFO entry rss", 32'(rss), 32'hFF);
        mode = 2'b10;
        wait_for_data("11n", n);
        check("11n INFO->DATA cycles", 32'(n), 20);
        run_bits("11n", 16, 1'b0, 32'h0);

        // Abort at payload bit 5.
        trig = 1'b0;
        step();
        trig = 1'b1;
        step();
        wait_for_data("abort", n);
        repeat (5 * CPU) step();
        check("abort bit5 value", 32'(mod_bit), 32'(payload_bit(5)));
        trig = 1'b0;
        step();
        check("abort busy", 32'(busy), 0);
        check("abort fs_en", 32'(fs_en), 0);
        check("abort mod_active", 32'(mod_active), 0);
        check("abort rom_addr", 32'(bus.rom_addr), 0);
        check("abort frame_done", 32'(frame_done), 0);
        count_done("abort", 8, 0);

        // force_fs mid-DATA, then release with trig high.
        trig = 1'b1;
        step();
        wait_for_data("force", n);
        repeat (6) step();
        force_fs = 1'b1;
        step();
        check("force fs_en", 32'(fs_en), 1);
        check("force mod_active", 32'(mod_active), 0);
        check("force mod_bit", 32'(mod_bit), 0);
        check("force busy", 32'(busy), 0);
        check("force rom_addr", 32'(bus.rom_addr), 0);
        force_fs = 1'b0;
        step();
        check("release fs_en", 32'(fs_en), 0);
        check("release busy", 32'(busy), 0);
        step();
        check("restart soc", 32'(bus.adc_soc), 1);
        check("restart busy", 32'(busy), 1);

        // Reset mid-FCS with force_fs and trig both high.
        repeat (10) step();
        bus.adc_eoc = 1'b1;
        bus.adc_data = 8'h3C;
        step();
        bus.adc_eoc = 1'b0;
        wait_for_data("fcs reset", n);
        repeat (72 * CPU + 8) step();
        check("in FCS before reset", 32'(mod_active), 1);
        check("rss before reset", 32'(rss), 32'h3C);
        force_fs = 1'b1;
        reset = 1'b1;
        step();
        check_reset_outputs("mid-FCS reset");
        reset = 1'b0;
        force_fs = 1'b0;
        trig = 1'b0;
        step();
        check("post reset busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tag_frame_sequencer.md
TAG_FRAME_SEQUENCER -- requirements
Module: tag_frame_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- CLK_PER_US, 50, clk cycles per microsecond tick (>=2).
- ADDR_W, 6, payload ROM address width.
- B_INFO_US, 3, 11b INFO duration in ticks (>=1).
- B_GAP_US, 141, 11b GAP duration in ticks (>=1).
- B_LEN_BYTES, 40, 11b payload length in bytes (1..2^ADDR_W).
- B_CRC_EN, 1, append a 32-bit FCS in 11b mode.
- N_INFO_US, 2, 11n INFO duration in ticks.
- N_GAP_US, 64, 11n GAP duration in ticks.
- N_LEN_BYTES, 16, 11n payload length in bytes.
- N_CRC_EN, 0, append a 32-bit FCS in 11n mode.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning. Clock and reset are listed first.
- clk, in, 1, clock.
- reset, in, 1, synchronous reset, active-high.
- trig, in, 1, packet-present envelope.
- force_fs, in, 1, force frequency-shift carrier.
- mode, in, 2, mode select: 10=11b, 01=11n, other=idle.
- rom_addr, out, ADDR_W, payload ROM address.
- rom_data, in, 8, payload ROM data, valid 1 cycle after rom_addr.
- adc_soc, out, 1, ADC start pulse.
- adc_eoc, in, 1, ADC conversion done.
- adc_data, in, 8, ADC result.
- rss, out, 8, captured signal strength.
- fs_en, out, 1, carrier enable.
- mod_bit, out, 1, modulation bit.
- mod_active, out, 1, mod_bit is meaningful.
- frame_done, out, 1, one-cycle pulse at frame end.
- busy, out, 1, state is not IDLE or FORCE.

Function
REQ-003 States SHALL be IDLE, FORCE, INFO, GAP, DATA, FCS and WAIT_END.
REQ-004 Tick generation:
- The divider SHALL clear on every state entry.
- A tick SHALL occur when the divider reaches CLK_PER_US-1, so the first tick comes CLK_PER_US cycles after entry.
- The tick counter SHALL count ticks since state entry.
REQ-005 Priority, evaluated every cycle: force_fs forces FORCE; otherwise trig=0 forces IDLE; otherwise the normal transition applies.
REQ-006 IDLE exit:
- With trig=1 and mode=10 or 01, the block SHALL latch the mode and enter INFO.
- With any other mode value, it SHALL stay in IDLE.
- mode changes after the latch SHALL be ignored until the next IDLE.
REQ-007 INFO:
- adc_soc SHALL be 1 for exactly the first cycle in INFO.
- The block SHALL move to GAP after INFO_US ticks of the latched mode.
REQ-008 rss SHALL capture adc_data on any cycle with adc_eoc=1 while in INFO or GAP, and SHALL hold otherwise until the next INFO entry, which sets rss to 0xFF.
REQ-009 GAP: rom_addr SHALL be 0; after GAP_US ticks the block SHALL enter DATA.
REQ-010 DATA serialisation:
- On DATA entry, byte 0 (rom_data) SHALL load the shift register and rom_addr SHALL become 1.
- Bits SHALL be sent LSB-first, one per tick interval.
- After the 8th bit, the next byte SHALL load from rom_data and rom_addr SHALL increment.
- DATA SHALL last LEN_BYTES*8 ticks.
REQ-011 mod_bit SHALL present payload bit k from the cycle DATA is entered plus k*CLK_PER_US cycles, held for CLK_PER_US cycles.
REQ-012 FCS computation:
- The CRC SHALL be reflected CRC-32: register initialised to 0xFFFFFFFF at DATA entry.
- Each sent bit b SHALL update crc = (crc>>1) ^ (0xEDB88320 if crc[0]^b).
REQ-013 FCS transmission:
- If CRC_EN is set, DATA SHALL be followed by FCS for 32 ticks, sending ~crc LSB-first with the same timing as REQ-011.
- If CRC_EN is clear, DATA SHALL go directly to WAIT_END.
REQ-014 frame_done SHALL pulse for 1 cycle on WAIT_END entry; WAIT_END SHALL hold until trig=0.
REQ-015 Outputs by state:
- fs_en SHALL be 1 in all states except IDLE.
- mod_active SHALL be 1 only in DATA and FCS.
- mod_bit SHALL be 0 whenever mod_active is 0.
REQ-016 A trig drop or force_fs in any state SHALL abort the frame within 1 cycle, with no frame_done pulse.
REQ-017 rom_addr SHALL return to 0 on IDLE or FORCE.

Reset
REQ-018 While reset is high:
- state SHALL be IDLE and the divider and counters SHALL be 0.
- rom_addr, adc_soc, fs_en, mod_bit, mod_active, frame_done and busy SHALL be 0.
- rss SHALL be 0xFF.
REQ-019 reset SHALL override force_fs and trig, including mid-frame.

Verification (CLK_PER_US=4)
REQ-020 The bench SHALL cover these scenarios:
- 11b FCS vector: B_LEN_BYTES=9, ROM="123456789", mode=10, trig held high -> FCS bits equal ~crc=0xCBF43926 LSB-first (first 8 bits 0,1,1,0,0,1,0,0); frame_done pulses once.
- 11n timing: mode=01, N_INFO_US=2, N_GAP_US=3, N_LEN_BYTES=2, N_CRC_EN=0 -> DATA entered exactly 20 cycles after INFO entry, lasts 64 cycles, then WAIT_END.
- ADC capture: adc_eoc=1 with adc_data=0x5A during GAP -> rss=0x5A through WAIT_END; the next INFO entry restores 0xFF.
- Abort: trig=0 at payload bit 5 -> IDLE next cycle, mod_active=0, rom_addr=0, no frame_done.
- force_fs asserted mid-DATA -> FORCE, fs_en=1, mod_active=0; on release with trig=1 -> IDLE, then a new frame starts.
- mode=11 with trig=1 -> stays in IDLE with busy=0; reset mid-FCS -> all outputs at REQ-018 values on the next cycle.
